// File: rtl/spiflash_shift_engine.sv
// SPI mode-0 master byte engine: pops bytes from a show-ahead TX FIFO, shifts them out
// MSB-first, and optionally pushes the bytes captured on MISO into an RX FIFO.
module spiflash_shift_engine #(
  parameter int CLKDIV = 2,
  parameter int LENW   = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [LENW-1:0] i_len,
  input  logic            i_rx_en,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_tx_rd,
  input  logic [7:0]      i_tx_data,
  input  logic            i_tx_empty,
  output logic            o_rx_wr_en,
  output logic [7:0]      o_rx_data,
  input  logic            i_rx_full,
  output logic            o_sclk,
  output logic            o_cs_n,
  output logic            o_mosi,
  input  logic            i_miso
);

  localparam int DIV_W = $clog2(CLKDIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [LENW-1:0]   byte_cnt_reg, byte_cnt_next;
  logic              rx_en_reg, rx_en_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        cap_reg, cap_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              tx_rd_reg, tx_rd_next;
  logic              rx_wr_reg, rx_wr_next;
  logic [7:0]        rx_data_reg, rx_data_next;
  logic              sclk_reg, sclk_next;
  logic              cs_n_reg, cs_n_next;
  logic              mosi_reg, mosi_next;
  logic              div_last;

  assign div_last = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      rx_en_reg    <= 1'b0;
      shift_reg    <= '0;
      cap_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      tx_rd_reg    <= 1'b0;
      rx_wr_reg    <= 1'b0;
      rx_data_reg  <= '0;
      sclk_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      rx_en_reg    <= rx_en_next;
      shift_reg    <= shift_next;
      cap_reg      <= cap_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      tx_rd_reg    <= tx_rd_next;
      rx_wr_reg    <= rx_wr_next;
      rx_data_reg  <= rx_data_next;
      sclk_reg     <= sclk_next;
      cs_n_reg     <= cs_n_next;
      mosi_reg     <= mosi_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    rx_en_next    = rx_en_reg;
    shift_next    = shift_reg;
    cap_next      = cap_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    tx_rd_next    = 1'b0;
    rx_wr_next    = 1'b0;
    rx_data_next  = rx_data_reg;
    sclk_next     = sclk_reg;
    cs_n_next     = cs_n_reg;
    mosi_next     = mosi_reg;

    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        // The done cycle itself is not an accept slot; a start is taken the cycle after.
        if (i_start && (i_len != '0) && !done_reg) begin
          byte_cnt_next = i_len;
          rx_en_next    = i_rx_en;
          cs_n_next     = 1'b0;
          busy_next     = 1'b1;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          div_cnt_next = '0;
          state_next   = LOAD;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      LOAD: begin
        // RX space is reserved here so the push at the end of the byte can never overflow.
        if (!i_tx_empty && !(rx_en_reg && i_rx_full)) begin
          tx_rd_next   = 1'b1;
          shift_next   = i_tx_data;
          mosi_next    = i_tx_data[7];
          bit_cnt_next = 3'd7;
          div_cnt_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (!div_last) begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end else begin
          div_cnt_next = '0;
          if (!sclk_reg) begin
            sclk_next = 1'b1;
            cap_next  = {cap_reg[6:0], i_miso};
          end else begin
            sclk_next = 1'b0;
            if (bit_cnt_reg == 3'd0) begin
              rx_wr_next    = rx_en_reg;
              rx_data_next  = cap_reg;
              byte_cnt_next = byte_cnt_reg - LENW'(1);
              state_next    = (byte_cnt_reg == LENW'(1)) ? HOLD : LOAD;
            end else begin
              bit_cnt_next = bit_cnt_reg - 3'd1;
              shift_next   = {shift_reg[6:0], 1'b0};
              mosi_next    = shift_reg[6];
            end
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          div_cnt_next = '0;
          cs_n_next    = 1'b1;
          mosi_next    = 1'b0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = IDLE;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy     = busy_reg;
  assign o_done     = done_reg;
  assign o_tx_rd    = tx_rd_reg;
  assign o_rx_wr_en = rx_wr_reg;
  assign o_rx_data  = rx_data_reg;
  assign o_sclk     = sclk_reg;
  assign o_cs_n     = cs_n_reg;
  assign o_mosi     = mosi_reg;

endmodule

// File: tb/tb_spiflash_shift_engine.sv
// Directed bench for spiflash_shift_engine with FIFO and SPI slave models (CLKDIV=2).
module tb_spiflash_shift_engine;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_rx_en, i_rx_full;
  logic [15:0] i_len;
  logic        o_busy, o_done, o_tx_rd, o_rx_wr_en, o_sclk, o_cs_n, o_mosi, i_miso;
  logic [7:0]  i_tx_data, o_rx_data;
  logic        i_tx_empty;

  always #5 clk = ~clk;

  spiflash_shift_engine #(.CLKDIV(2), .LENW(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len), .i_rx_en(i_rx_en),
    .o_busy(o_busy), .o_done(o_done), .o_tx_rd(o_tx_rd), .i_tx_data(i_tx_data),
    .i_tx_empty(i_tx_empty), .o_rx_wr_en(o_rx_wr_en), .o_rx_data(o_rx_data),
    .i_rx_full(i_rx_full), .o_sclk(o_sclk), .o_cs_n(o_cs_n), .o_mosi(o_mosi), .i_miso(i_miso)
  );

  // TX FIFO model: written by the stimulus, popped by the monitor
  logic [7:0] tx_mem [0:63];
  logic [5:0] tx_wp = '0, tx_rp = '0;
  assign i_tx_data  = tx_mem[tx_rp];
  assign i_tx_empty = (tx_wp == tx_rp);

  // SPI slave model: one byte per 8 SCLK rising edges, restarting at each CS fall
  logic [7:0] miso_bytes [0:7];
  logic [2:0] miso_idx = '0, miso_bit = '0;
  assign i_miso = miso_bytes[miso_idx][3'd7 - miso_bit];

  int          pops = 0, rx_n = 0, done_cnt = 0, cs_low = 0, rises = 0, viol = 0;
  logic [31:0] mosi_log = '0;
  logic [7:0]  rx_got [0:63];
  logic        cur_rx_en = 1'b0;
  logic        sclk_prev = 1'b0, cs_prev = 1'b1;

  always @(negedge clk) begin
    if (o_tx_rd) begin
      pops++;
      if (tx_wp == tx_rp) viol++;
      else tx_rp++;
      if (o_sclk) viol++;
    end
    if (o_rx_wr_en) begin
      if (i_rx_full || !cur_rx_en) viol++;
      rx_got[rx_n[5:0]] = o_rx_data;
      rx_n++;
    end
    if (o_done) done_cnt++;
    if (!o_cs_n) cs_low++;
    if (o_sclk && !sclk_prev) begin
      rises++;
      mosi_log = {mosi_log[30:0], o_mosi};
      if (miso_bit == 3'd7) begin
        miso_bit = '0;
        miso_idx++;
      end else begin
        miso_bit++;
      end
    end
    if (!o_cs_n && cs_prev) begin
      miso_idx = '0;
      miso_bit = '0;
    end
    sclk_prev = o_sclk;
    cs_prev   = o_cs_n;
  end

  int tests_run = 0, tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_wp] = b;
    tx_wp++;
  endtask

  task automatic start_xfer(input logic [15:0] len, input logic rx_en);
    @(negedge clk);
    i_len = len; i_rx_en = rx_en; cur_rx_en = rx_en; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!o_done && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, o_done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_rises(input int target, input int max);
    int n = 0;
    while (rises < target && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  int p0, r0, c0, d0, s0, p1, r1, c1, s1, stall_bad, n;

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_len = '0; i_rx_en = 1'b0; i_rx_full = 1'b0;
    for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {25'd0, o_cs_n, o_sclk, o_mosi, o_busy, o_done, o_tx_rd, o_rx_wr_en},
          32'b1000000);
    check("reset_rx_data", {24'd0, o_rx_data}, 32'h0);
    i_reset = 1'b0;

    // single byte, no capture
    p0 = pops; r0 = rx_n; c0 = cs_low; d0 = done_cnt; s0 = rises;
    push_tx(8'hA5);
    start_xfer(16'd1, 1'b0);
    check("t1_busy", {31'd0, o_busy}, 32'd1);
    wait_done("t1_done", 200);
    check("t1_pops", pops - p0, 1);
    check("t1_rises", rises - s0, 8);
    check("t1_mosi", {24'd0, mosi_log[7:0]}, 32'hA5);
    check("t1_cs_low", cs_low - c0, 37);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_pushes", rx_n - r0, 0);

    // three bytes with capture
    p0 = pops; r0 = rx_n; s0 = rises;
    miso_bytes[0] = 8'h00; miso_bytes[1] = 8'h5A; miso_bytes[2] = 8'hC3;
    push_tx(8'h03); push_tx(8'h00); push_tx(8'h10);
    start_xfer(16'd3, 1'b1);
    wait_done("t2_done", 400);
    check("t2_pops", pops - p0, 3);
    check("t2_pushes", rx_n - r0, 3);
    check("t2_rx0", {24'd0, rx_got[r0[5:0]]}, 32'h00);
    check("t2_rx1", {24'd0, rx_got[r0[5:0] + 6'd1]}, 32'h5A);
    check("t2_rx2", {24'd0, rx_got[r0[5:0] + 6'd2]}, 32'hC3);
    check("t2_mosi", {8'd0, mosi_log[23:0]}, 32'h030010);
    check("t2_rises", rises - s0, 24);

    // TX underrun between bytes
    p0 = pops; s0 = rises;
    push_tx(8'h81);
    start_xfer(16'd2, 1'b0);
    wait_rises(s0 + 8, 200);
    repeat (6) @(negedge clk);
    s1 = rises; stall_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_cs_n || o_sclk || !o_busy) stall_bad++;
    end
    check("t3_stall_lines", stall_bad, 0);
    check("t3_stall_rises", rises - s1, 0);
    check("t3_stall_pops", pops - p0, 1);
    push_tx(8'h7E);
    wait_done("t3_done", 200);
    check("t3_pops", pops - p0, 2);
    check("t3_mosi", {16'd0, mosi_log[15:0]}, 32'h817E);

    // RX full before byte 2
    r0 = rx_n; s0 = rises;
    miso_bytes[0] = 8'h96; miso_bytes[1] = 8'h4B;
    push_tx(8'h11); push_tx(8'h22);
    start_xfer(16'd2, 1'b1);
    n = 0;
    while (!o_rx_wr_en && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_push1_seen", {31'd0, o_rx_wr_en}, 32'd1);
    #1 i_rx_full = 1'b1;
    s1 = rises; r1 = rx_n;
    repeat (10) @(negedge clk);
    check("t4_stall_rises", rises - s1, 0);
    check("t4_stall_pushes", rx_n - r1, 0);
    i_rx_full = 1'b0;
    wait_done("t4_done", 200);
    check("t4_pushes", rx_n - r0, 2);
    check("t4_rx0", {24'd0, rx_got[r0[5:0]]}, 32'h96);
    check("t4_rx1", {24'd0, rx_got[r0[5:0] + 6'd1]}, 32'h4B);

    // reset mid-byte
    s0 = rises;
    push_tx(8'hC6);
    start_xfer(16'd3, 1'b0);
    wait_rises(s0 + 4, 200);
    i_reset = 1'b1;
    @(negedge clk);
    check("t5_after_reset", {27'd0, o_cs_n, o_sclk, o_busy, o_done, o_mosi}, 32'b10000);
    i_reset = 1'b0;
    p1 = pops; r1 = rx_n; c1 = cs_low;
    repeat (40) @(negedge clk);
    check("t5_no_pops", pops - p1, 0);
    check("t5_no_cs", cs_low - c1, 0);
    miso_bytes[0] = 8'h3C;
    push_tx(8'h9F);
    start_xfer(16'd1, 1'b1);
    wait_done("t5_done", 200);
    check("t5_mosi", {24'd0, mosi_log[7:0]}, 32'h9F);
    check("t5_pushes", rx_n - r1, 1);
    check("t5_rx", {24'd0, rx_got[r1[5:0]]}, 32'h3C);
    check("t5_pops", pops - p1, 1);

    // zero length and start while busy
    c0 = cs_low;
    @(negedge clk);
    i_len = '0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_zero_len_cs", cs_low - c0, 0);
    check("t6_zero_len_busy", {31'd0, o_busy}, 32'd0);
    p0 = pops; d0 = done_cnt;
    push_tx(8'h5A);
    start_xfer(16'd1, 1'b0);
    repeat (10) @(negedge clk);
    i_len = 16'd5; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("t6_done", 200);
    repeat (20) @(negedge clk);
    check("t6_pops", pops - p0, 1);
    check("t6_done_cnt", done_cnt - d0, 1);
    check("t6_mosi", {24'd0, mosi_log[7:0]}, 32'h5A);
    check("t6_cs_low", cs_low - c0, 37);

    check("protocol_viol", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spiflash_shift_engine.md
Name: spiflash_shift_engine

Overview:
- SPI mode-0 master byte engine for the SPI flash controller.
- Drains command/data bytes from the TX sync FIFO read side (show-ahead data, rd/empty) and serialises them MSB-first on MOSI.
- Optionally captures MISO bytes into the RX sync FIFO write side (wr_en/data/full).
- Sequenced by the flash controller FSM via start/len/done.

Parameters:
- CLKDIV, 2, i_clk cycles per SCLK half-period; legal range >= 1.
- LENW, 16, width of the byte-count input.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_start  input  1  start transfer; sampled only in IDLE
- i_len  input  LENW  bytes to transfer; 0 means no transfer
- i_rx_en  input  1  capture MISO bytes into the RX FIFO; latched at start
- o_busy  output  1  high from the cycle after an accepted start until done
- o_done  output  1  one-cycle pulse when the transfer completes
- o_tx_rd  output  1  TX FIFO pop strobe
- i_tx_data  input  8  TX FIFO head byte (show-ahead)
- i_tx_empty  input  1  TX FIFO empty
- o_rx_wr_en  output  1  RX FIFO push strobe
- o_rx_data  output  8  captured byte
- i_rx_full  input  1  RX FIFO full
- o_sclk  output  1  SPI clock; idles low
- o_cs_n  output  1  chip select, active low
- o_mosi  output  1  serial data out
- i_miso  input  1  serial data in

Behaviour:
- All outputs are registered.
- Reset values: o_cs_n=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, o_tx_rd=0, o_rx_wr_en=0, o_rx_data=0. State=IDLE.
- Reset mid-transfer: the next cycle shows the reset values, the byte count is discarded, and no further FIFO strobes are issued.
- FSM states are IDLE, SETUP, LOAD, SHIFT, HOLD.
- IDLE:
  - i_start=1 and i_len!=0: latch i_len and i_rx_en, then go to SETUP. o_cs_n=0 and o_busy=1 from the next cycle.
  - i_start=1 and i_len==0: ignored.
  - i_start while busy: ignored.
- SETUP: hold CS low with SCLK low for CLKDIV cycles, then go to LOAD.
- LOAD: wait while i_tx_empty=1, or while (rx_en latched and i_rx_full=1). SCLK stays low and CS stays asserted while waiting. When neither condition holds:
  - assert o_tx_rd for exactly one cycle;
  - load i_tx_data into the shift register;
  - o_mosi = bit7 on the next cycle;
  - go to SHIFT.
- SHIFT (per bit, MSB first):
  - SCLK low for CLKDIV cycles.
  - Rising edge: SCLK=1 and sample i_miso into the capture register LSB.
  - SCLK high for CLKDIV cycles.
  - Falling edge: SCLK=0, shift out the next bit onto o_mosi.
- A byte occupies 16*CLKDIV cycles of SCLK activity.
- After the falling edge of bit 0:
  - if rx_en is latched, pulse o_rx_wr_en for one cycle with o_rx_data = captured byte. Space was checked in LOAD; only this block writes the RX FIFO, so the FIFO cannot be full at the push.
  - decrement the remaining count.
  - count != 0: go to LOAD. An inter-byte gap of at least one cycle is permitted.
  - count == 0: go to HOLD.
- HOLD: CS low and SCLK low for CLKDIV cycles. Then o_cs_n=1, o_mosi=0, o_busy=0, o_done=1 for one cycle, and return to IDLE.
- A new start is accepted in the cycle after o_done.
- o_tx_rd is never asserted while i_tx_empty=1.
- o_rx_wr_en is never asserted while i_rx_full=1 or while rx_en is 0.
- Exactly i_len TX pops occur per transfer. Exactly i_len RX pushes occur when rx_en is set, and none otherwise.
- Widths:
  - the half-period counter is $clog2(CLKDIV+1) bits and wraps at CLKDIV-1;
  - the bit counter is 3 bits;
  - the byte count is LENW bits, with no underflow because a zero length is rejected at start.

Test Plan:
- CLKDIV=2, TX FIFO holds 0xA5, i_len=1, rx_en=0 -> one o_tx_rd pulse; MOSI sampled on 8 SCLK rising edges reads 1,0,1,0,0,1,0,1; o_cs_n low for 2+32+2 cycles plus the LOAD cycle; one o_done pulse; zero o_rx_wr_en.
- i_len=3, rx_en=1, TX bytes 0x03,0x00,0x10, MISO model returns 0x00,0x5A,0xC3 -> three pops, three pushes with o_rx_data 0x00,0x5A,0xC3 in order; SCLK stays low between bytes.
- i_len=2 with TX FIFO empty after byte 1; refill 20 cycles later -> engine stalls in LOAD with CS low and SCLK low; no pop while empty; byte 2 sent after refill; done follows.
- rx_en=1 with i_rx_full=1 before byte 2 for 10 cycles -> no SCLK edges and no push during the stall; resumes when full drops; all bytes captured correctly.
- Assert i_reset during bit 4 of byte 1 -> next cycle o_cs_n=1, o_sclk=0, o_busy=0; no further strobes; a new start with 0x9F completes normally.
- i_start with i_len=0, and i_start while busy -> both ignored: no CS activity for the zero-length request, and the in-flight transfer is unaffected.
